alu_op_arbiter: RTL
===================

# alu_op_arbiter

Sequencer and two-port arbiter for the shared 4-bit ALU datapath. It accepts operation requests (A, B, OpCode) from two independent requesters and grants one at a time. It executes the operation (add, subtract, OR, AND with carry-out) in a registered compute stage and returns Result/Cout to the granted requester over a valid/ready response handshake. It sits between the instruction-issue logic and the ALU, so the two clients never drive the datapath at the same time.

## Interface
- WIDTH, 4, operand/result width in bits.
- Clk  input  1  sole clock; all state updates on rising edge.
- Reset  input  1  synchronous, active-high reset.
- ReqValid  input  2  bit i: requester i presents an operation.
- ReqReady  output  2  bit i: arbiter accepts requester i this cycle; at most one bit high.
- ReqA  input  2*WIDTH  operand A; requester i in bits [i*WIDTH +: WIDTH].
- ReqB  input  2*WIDTH  operand B; same packing.
- ReqOpCode  input  6  3-bit opcode per requester; requester i in bits [i*3 +: 3].
- RspValid  output  2  bit i: response for requester i is valid; at most one bit high.
- RspReady  input  2  bit i: requester i consumes the response.
- RspResult  output  WIDTH  result, shared by both requesters and qualified by RspValid.
- RspCout  output  1  carry-out for add/sub; 0 for logic ops.
- RspErr  output  1  1 when the accepted opcode was illegal.
- Busy  output  1  high whenever state is not IDLE.

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If no ReqValid bit is high, ReqReady=0 and the FSM stays in IDLE.
  - Otherwise the arbiter picks grant g and drives ReqReady[g]=1 combinationally. On ReqValid[g]&ReqReady[g] it latches A, B, OpCode and g, then moves to EXEC.
- EXEC: one cycle. Computes the operation and registers RspResult/RspCout/RspErr, then moves to RESP.
- RESP: RspValid[g]=1. Result fields are held stable until RspReady[g]=1, then the FSM moves to IDLE. RspReady[!g] is ignored.
- ReqReady=0 in EXEC and RESP; requesters hold their requests.
- Opcode rules:
  - 001: add. Sum = A+B; Cout = bit WIDTH of the (WIDTH+1)-bit sum.
  - 000: subtract. A + ~B + 1; Cout = carry-out (1 = no borrow).
  - 010: bitwise OR, Cout=0.
  - 011: bitwise AND, Cout=0.
  - 100–111: illegal. Result=0, Cout=0, Err=1.
- All arithmetic is modulo 2^WIDTH; no saturation.
- Arbitration depends on the configuration macro. When only one requester is valid, that requester is granted in either mode.
- Reset: state=IDLE, ReqReady=0, RspValid=0, RspResult=0, RspCout=0, RspErr=0, Busy=0, LastGrant=1. Requester 0 wins the first contention.
- Reset mid-operation: any in-flight operation or pending response is discarded with no response, and the next cycle is IDLE.

## Timing
- Request accepted at edge T (handshake in cycle T-1 → T).
- FSM is in EXEC in cycle T and RESP in cycle T+1, so RspValid is high from cycle T+1.
- Minimum request-to-response latency: 2 cycles.
- Minimum spacing between accepts: 3 cycles (accept, EXEC, RESP with immediate RspReady).
- A response consumed at edge U puts the FSM in IDLE in cycle U, so a new grant is possible in that cycle.
- ReqReady depends combinationally only on ReqValid, state and LastGrant; there is no path from RspReady.
- Busy is registered state: high from edge T until RESP exits.

## Configuration
- ALU_ARB_RR_EN defined: round-robin arbitration.
  - When both requesters are valid in IDLE, grant goes to !LastGrant.
  - LastGrant updates on every accepted request.
- ALU_ARB_RR_EN undefined: fixed priority, requester 0 always wins contention.
  - LastGrant logic is removed.
  - Requester 1 can starve; this is acceptable for single-client builds.

## Test plan
- Add with carry: req0 A=4'h9, B=4'h8, op 001 → RspValid[0] two cycles after accept, RspResult=4'h1, RspCout=1, RspErr=0.
- Subtract with borrow: req1 A=4'h3, B=4'h5, op 000 → RspValid[1], RspResult=4'hE, RspCout=0. Also A=5, B=3 → 4'h2, Cout=1.
- Contention: both ReqValid held high continuously with RspReady=2'b11:
  - RR build: grants alternate 0,1,0,1.
  - Fixed build: grants are 0,0,0.
- Backpressure: op 010 with A=4'hA, B=4'h5 and RspReady held 0 for 5 cycles → RspResult=4'hF stays stable, ReqReady=2'b00 and Busy=1 throughout; RspReady=1 → IDLE on the next cycle.
- Illegal opcode: op 111 → RspResult=0, RspCout=0, RspErr=1. A following op 011 with A=4'hC, B=4'hA → 4'h8, RspErr=0.
- Reset in EXEC: assert Reset for 1 cycle → no RspValid ever pulses for that request, all outputs 0, next request served normally.

Source files
------------

// File: rtl/alu_op_arbiter.sv
// alu_op_arbiter: two-port arbiter and sequencer for the shared ALU; ALU_ARB_RR_EN selects round-robin
module alu_op_arbiter #(
    parameter int WIDTH = 4
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic [1:0]           ReqValid,
    output logic [1:0]           ReqReady,
    input  logic [2*WIDTH-1:0]   ReqA,
    input  logic [2*WIDTH-1:0]   ReqB,
    input  logic [5:0]           ReqOpCode,
    output logic [1:0]           RspValid,
    input  logic [1:0]           RspReady,
    output logic [WIDTH-1:0]     RspResult,
    output logic                 RspCout,
    output logic                 RspErr,
    output logic                 Busy
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]       stateReg;
    logic             grantReg;
    logic             grantSel;
    logic [WIDTH-1:0] aReg;
    logic [WIDTH-1:0] bReg;
    logic [2:0]       opReg;
    logic             isSub;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] aluRes;
    logic             aluCout;

`ifdef ALU_ARB_RR_EN
    logic lastGrant;

    // Round-robin: on contention the requester not served last wins
    always_comb grantSel = &ReqValid ? ~lastGrant : ReqValid[1];

    // Remember who was accepted most recently
    always_ff @(posedge Clk)
        if (Reset)
            lastGrant <= 1'b1;
        else if (stateReg == IDLE && |ReqValid)
            lastGrant <= grantSel;
`else
    // Fixed priority: requester 0 wins whenever it is valid
    always_comb grantSel = ~ReqValid[0];
`endif

    // Request/response handshakes are pure decodes of state and grant
    always_comb begin
        ReqReady = (stateReg == IDLE && |ReqValid) ? (grantSel ? 2'b10 : 2'b01) : 2'b00;
        RspValid = (stateReg == RESP) ? (grantReg ? 2'b10 : 2'b01) : 2'b00;
        Busy     = stateReg != IDLE;
    end

    // Subtract reuses the adder as A + ~B + 1 so Cout means "no borrow"
    always_comb begin
        isSub   = opReg == 3'b000;
        sum     = {1'b0, aReg} + {1'b0, isSub ? ~bReg : bReg} + {{WIDTH{1'b0}}, isSub};
        aluRes  = opReg[2] ? '0 : opReg[1] ? (opReg[0] ? aReg & bReg : aReg | bReg) : sum[WIDTH-1:0];
        aluCout = ~opReg[2] & ~opReg[1] & sum[WIDTH];
    end

    // IDLE -> EXEC on accept, EXEC -> RESP after compute, RESP -> IDLE when the granted side consumes
    always_ff @(posedge Clk) begin
        if (Reset) begin
            stateReg  <= IDLE;
            grantReg  <= 1'b0;
            RspResult <= '0;
            RspCout   <= 1'b0;
            RspErr    <= 1'b0;
        end else begin
            case (stateReg)
                IDLE: if (|ReqValid) begin
                    aReg     <= grantSel ? ReqA[2*WIDTH-1:WIDTH] : ReqA[WIDTH-1:0];
                    bReg     <= grantSel ? ReqB[2*WIDTH-1:WIDTH] : ReqB[WIDTH-1:0];
                    opReg    <= grantSel ? ReqOpCode[5:3] : ReqOpCode[2:0];
                    grantReg <= grantSel;
                    stateReg <= EXEC;
                end
                EXEC: begin
                    RspResult <= aluRes;
                    RspCout   <= aluCout;
                    RspErr    <= opReg[2];
                    stateReg  <= RESP;
                end
                RESP: if (RspReady[grantReg]) stateReg <= IDLE;
                default: stateReg <= IDLE;
            endcase
        end
    end
endmodule
